policy_sel: RTL and testbench
=============================

POLICY_SEL -- requirements
Module: policy_sel

Interface
REQ-001 SHALL have parameter N_ACT, default 9: number of actions/cells.
REQ-002 SHALL have parameter Q_W, default 18: Q-value width.
REQ-003 SHALL have parameter ACT_W, default 4: action code width, sized to hold N_ACT.
REQ-004 SHALL have parameter EPS_W, default 8: exploration threshold width.
REQ-005 SHALL have parameter Q_SIGNED, default 0: 1 selects two's-complement compare, 0 selects unsigned compare.
REQ-006 SHALL have parameter LFSR_SEED, default 16'hACE1: nonzero LFSR reset value.
REQ-007 SHALL have ports, in this order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request a decision.
- q_flat  in  N_ACT*Q_W  Q-values; bits [Q_W-1:0] belong to cell 1.
- legal_mask  in  N_ACT  bit i=1: cell i+1 playable.
- explore_en  in  1  enable epsilon-greedy.
- eps  in  EPS_W  exploration threshold.
- busy  out  1  decision in progress.
- done  out  1  one-cycle result strobe.
- next_action  out  ACT_W  chosen cell 1..N_ACT; 0 = no legal move.
- best_q  out  Q_W  Q of chosen cell; 0 if none.
- explored  out  1  result came from exploration.

Function
REQ-008 SHALL run FSM IDLE -> SCAN -> DONE -> IDLE; start is accepted only in IDLE and ignored in SCAN and DONE.
REQ-009 SHALL snapshot q_flat, legal_mask and the mode decision on the edge that accepts start; input changes after that edge SHALL NOT affect the result.
REQ-010 Mode decision SHALL be explore iff explore_en=1 and (eps all-ones, or lfsr[EPS_W-1:0] < eps); otherwise greedy.
REQ-011 SCAN SHALL examine exactly one index per cycle, for N_ACT cycles; busy=1 in SCAN and DONE.
REQ-012 Greedy mode SHALL scan index order 0..N_ACT-1 and replace the candidate only on a legal, strictly greater Q; ties resolve to the lowest cell.
REQ-013 Explore mode SHALL scan circularly from offset off (captured at start) and choose the first legal index encountered.
REQ-014 off SHALL be a free-running counter: 0 in the first cycle after reset release, +1 per cycle, wrapping N_ACT-1 -> 0.
REQ-015 If start is accepted at edge t, done=1 SHALL hold for exactly cycle t+N_ACT+1 (DONE state), with the new outputs valid in that cycle.
REQ-016 next_action, best_q and explored SHALL hold their values until the next done.
REQ-017 legal_mask all-zero SHALL give next_action=0, best_q=0 and the same latency.
REQ-018 A start that is high in the DONE cycle SHALL be ignored; a start in the following IDLE cycle SHALL be accepted.
REQ-019 The LFSR SHALL advance every cycle: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.

Reset
REQ-020 rst SHALL force IDLE, busy=0, done=0, next_action=0, best_q=0, explored=0, off=0 and lfsr=LFSR_SEED.
REQ-021 rst asserted mid-SCAN SHALL abort the decision; no done SHALL follow the abort.

Structure
REQ-022 Package policy_pkg SHALL hold the FSM state encoding and the NO_ACTION=0 constant.
REQ-023 The LFSR SHALL be a sub-module named lfsr16, with parameter SEED.
REQ-024 Implementation SHALL use one comparator, iterated per cycle; no parallel N_ACT-way tree.

Verification
REQ-025 Greedy: Q={2,3,4,3,1,6,5,8,1}, mask=9'h1FF, explore_en=0 -> done at t+10, next_action=8, best_q=8.
REQ-026 Masked greedy: Q={10,25,23,9,12,17,55,8,16}, mask=9'h1BF -> next_action=2, best_q=25.
REQ-027 Tie and sign: all Q=5 -> next_action=1; Q_1=18'h20000, Q_2=1, others 0 -> next_action=1 with Q_SIGNED=0, next_action=2 with Q_SIGNED=1.
REQ-028 Explore: eps=8'hFF, explore_en=1, mask=9'h024, start accepted with off=4 -> next_action=6, explored=1.
REQ-029 Mask=0 -> next_action=0, best_q=0, done at t+10.
REQ-030 Aborts and ignored starts: rst at t+4 -> no done and outputs zero; start pulsed during SCAN -> no extra decision.

Source files
------------

// File: rtl/policy_pkg.sv
// Shared definitions for the policy selector: FSM state encoding and the
// action code that means "no legal move".
package policy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int NO_ACTION = 0;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1, advancing every cycle.
// Only the low OUT_W bits are exported; they feed the exploration compare.
module lfsr16 #(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int          OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    output logic [OUT_W-1:0] lfsr_o
);

    localparam logic [15:0] TAPS = 16'hB400;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q >> 1;
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ TAPS;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/policy_sel.sv
// Epsilon-greedy action selector: one shared comparator walks the Q-values
// one cell per cycle, either greedily (max Q) or from a rotating offset.
//
// state | meaning
// IDLE  | waiting for start; inputs are snapshotted on the accepting edge
// SCAN  | one cell examined per cycle for N_ACT cycles
// DONE  | one-cycle result strobe; start ignored here
module policy_sel
    import policy_pkg::*;
#(
    parameter int          N_ACT     = 9,
    parameter int          Q_W       = 18,
    parameter int          ACT_W     = 4,
    parameter int          EPS_W     = 8,
    parameter int          Q_SIGNED  = 0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_ACT*Q_W-1:0] q_flat,
    input  logic [N_ACT-1:0]   legal_mask,
    input  logic               explore_en,
    input  logic [EPS_W-1:0]   eps,
    output logic               busy,
    output logic               done,
    output logic [ACT_W-1:0]   next_action,
    output logic [Q_W-1:0]     best_q,
    output logic               explored
);

    localparam logic [ACT_W-1:0] LAST_IDX = ACT_W'(N_ACT - 1);
    localparam logic [ACT_W-1:0] ONE      = ACT_W'(1);

    state_e                 state_q, state_d;
    logic [N_ACT*Q_W-1:0]   q_snap_q, q_snap_d;
    logic [N_ACT-1:0]       mask_q, mask_d;
    logic                   explore_q, explore_d;
    logic [ACT_W-1:0]       idx_q, idx_d;
    logic [ACT_W-1:0]       cnt_q, cnt_d;
    logic [ACT_W-1:0]       off_q, off_d;
    logic                   cand_vld_q, cand_vld_d;
    logic [ACT_W-1:0]       cand_idx_q, cand_idx_d;
    logic [Q_W-1:0]         cand_val_q, cand_val_d;
    logic [ACT_W-1:0]       act_q, act_d;
    logic [Q_W-1:0]         bq_q, bq_d;
    logic                   expl_q, expl_d;

    logic [EPS_W-1:0]       lfsr_low;
    logic                   eps_hit;
    logic [Q_W-1:0]         cur_val;
    logic                   cur_legal;
    logic                   q_gt;
    logic                   take;
    logic                   fin_vld;
    logic [ACT_W-1:0]       fin_idx;
    logic [Q_W-1:0]         fin_val;
    logic [ACT_W-1:0]       idx_nxt;

    lfsr16 #(
        .SEED  (LFSR_SEED),
        .OUT_W (EPS_W)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .lfsr_o (lfsr_low)
    );

    assign eps_hit = explore_en && ((&eps) || (lfsr_low < eps));

    // The single comparator: current cell against the running candidate.
    assign cur_val   = q_snap_q[int'(idx_q)*Q_W +: Q_W];
    assign cur_legal = mask_q[idx_q];

    generate
        if (Q_SIGNED != 0) begin : g_cmp_signed
            assign q_gt = $signed(cur_val) > $signed(cand_val_q);
        end else begin : g_cmp_unsigned
            assign q_gt = cur_val > cand_val_q;
        end
    endgenerate

    // Explore takes the first legal cell only; greedy needs strictly greater Q.
    assign take    = cur_legal && (!cand_vld_q || (!explore_q && q_gt));
    assign fin_vld = take || cand_vld_q;
    assign fin_idx = take ? idx_q   : cand_idx_q;
    assign fin_val = take ? cur_val : cand_val_q;
    assign idx_nxt = (idx_q == LAST_IDX) ? '0 : idx_q + ONE;

    always_comb begin
        off_d = (off_q == LAST_IDX) ? '0 : off_q + ONE;
    end

    always_comb begin
        state_d    = state_q;
        q_snap_d   = q_snap_q;
        mask_d     = mask_q;
        explore_d  = explore_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        cand_vld_d = cand_vld_q;
        cand_idx_d = cand_idx_q;
        cand_val_d = cand_val_q;
        act_d      = act_q;
        bq_d       = bq_q;
        expl_d     = expl_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_SCAN;
                    q_snap_d   = q_flat;
                    mask_d     = legal_mask;
                    explore_d  = eps_hit;
                    idx_d      = eps_hit ? off_q : '0;
                    cnt_d      = '0;
                    cand_vld_d = 1'b0;
                    cand_idx_d = '0;
                    cand_val_d = '0;
                end
            end
            ST_SCAN: begin
                idx_d = idx_nxt;
                cnt_d = cnt_q + ONE;
                if (take) begin
                    cand_vld_d = 1'b1;
                    cand_idx_d = idx_q;
                    cand_val_d = cur_val;
                end
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    act_d   = fin_vld ? fin_idx + ONE : ACT_W'(NO_ACTION);
                    bq_d    = fin_vld ? fin_val : '0;
                    expl_d  = explore_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            q_snap_q   <= '0;
            mask_q     <= '0;
            explore_q  <= 1'b0;
            idx_q      <= '0;
            cnt_q      <= '0;
            off_q      <= '0;
            cand_vld_q <= 1'b0;
            cand_idx_q <= '0;
            cand_val_q <= '0;
            act_q      <= '0;
            bq_q       <= '0;
            expl_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            q_snap_q   <= q_snap_d;
            mask_q     <= mask_d;
            explore_q  <= explore_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            off_q      <= off_d;
            cand_vld_q <= cand_vld_d;
            cand_idx_q <= cand_idx_d;
            cand_val_q <= cand_val_d;
            act_q      <= act_d;
            bq_q       <= bq_d;
            expl_q     <= expl_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign next_action = act_q;
    assign best_q      = bq_q;
    assign explored    = expl_q;

endmodule

// File: tb/tb_policy_sel.sv
// Scoreboard bench for policy_sel: an unsigned and a signed instance share
// stimulus; expected results are queued at start and popped on done.
module tb_policy_sel;

    localparam int N  = 9;
    localparam int QW = 18;
    localparam int AW = 4;
    localparam int EW = 8;

    logic            clk;
    logic            rst;
    logic            start;
    logic [N*QW-1:0] q_flat;
    logic [N-1:0]    legal_mask;
    logic            explore_en;
    logic [EW-1:0]   eps;

    logic            busy_u, done_u, expl_u;
    logic [AW-1:0]   act_u;
    logic [QW-1:0]   bq_u;
    logic            busy_s, done_s, expl_s;
    logic [AW-1:0]   act_s;
    logic [QW-1:0]   bq_s;

    policy_sel #(.N_ACT(N), .Q_W(QW), .ACT_W(AW), .EPS_W(EW), .Q_SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .start(start), .q_flat(q_flat),
        .legal_mask(legal_mask), .explore_en(explore_en), .eps(eps),
        .busy(busy_u), .done(done_u), .next_action(act_u),
        .best_q(bq_u), .explored(expl_u)
    );

    policy_sel #(.N_ACT(N), .Q_W(QW), .ACT_W(AW), .EPS_W(EW), .Q_SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .start(start), .q_flat(q_flat),
        .legal_mask(legal_mask), .explore_en(explore_en), .eps(eps),
        .busy(busy_s), .done(done_s), .next_action(act_s),
        .best_q(bq_s), .explored(expl_s)
    );

    typedef struct {
        logic [AW-1:0] act;
        logic [QW-1:0] bq;
        logic          expl;
        logic [AW-1:0] act_s;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk    = 0;
    int   n_pass   = 0;
    int   done_cnt = 0;
    int   n_dec    = 0;
    int   off_m    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference for the free-running offset: 0 in the first cycle after reset.
    always @(posedge clk) begin
        if (rst) off_m <= 0;
        else     off_m <= (off_m == N-1) ? 0 : off_m + 1;
    end

    always @(negedge clk) begin
        if (done_u) done_cnt = done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [N*QW-1:0] pack(input int v[N]);
        logic [N*QW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i*QW +: QW] = QW'(v[i]);
        return r;
    endfunction

    function automatic logic [AW-1:0] ref_greedy(input logic [N*QW-1:0] qf, input logic [N-1:0] m,
                                                 input bit sgn, output logic [QW-1:0] bq);
        logic [AW-1:0] a;
        logic [QW-1:0] v;
        a  = '0;
        bq = '0;
        for (int i = 0; i < N; i++) begin
            if (m[i]) begin
                v = qf[i*QW +: QW];
                if (a == 0 || (sgn ? ($signed(v) > $signed(bq)) : (v > bq))) begin
                    a  = AW'(i + 1);
                    bq = v;
                end
            end
        end
        return a;
    endfunction

    function automatic logic [AW-1:0] ref_explore(input logic [N-1:0] m, input int off);
        for (int k = 0; k < N; k++) begin
            if (m[(off + k) % N]) return AW'((off + k) % N + 1);
        end
        return '0;
    endfunction

    task automatic push(input logic [AW-1:0] a, input logic [QW-1:0] bq, input logic ex,
                        input logic [AW-1:0] a_s);
        exp_t e;
        e.act = a; e.bq = bq; e.expl = ex; e.act_s = a_s;
        exp_q.push_back(e);
        n_dec = n_dec + 1;
    endtask

    // Called at a negedge while idle; returns just after the accepting edge
    // with the inputs scrambled so a missing snapshot shows up.
    task automatic accept(input logic [N*QW-1:0] qf, input logic [N-1:0] m,
                          input logic en, input logic [EW-1:0] e);
        q_flat = qf; legal_mask = m; explore_en = en; eps = e; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; q_flat = ~qf; legal_mask = ~m; explore_en = ~en; eps = ~e;
    endtask

    task automatic wait_done(input string tag, input int lat);
        int   seen_at;
        exp_t e;
        seen_at = 0;
        for (int k = 1; k <= lat + 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done_u) begin
                seen_at = k;
                break;
            end
        end
        chk({tag, "_latency"}, seen_at, lat);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (seen_at != 0) begin
                chk({tag, "_action"}, act_u, e.act);
                chk({tag, "_best_q"}, bq_u, e.bq);
                chk({tag, "_explored"}, expl_u, e.expl);
                chk({tag, "_action_signed"}, act_s, e.act_s);
                chk({tag, "_busy"}, busy_u, 1);
            end
        end
    endtask

    task automatic run(input string tag, input logic [N*QW-1:0] qf, input logic [N-1:0] m,
                       input logic en, input logic [EW-1:0] e, input logic [AW-1:0] a,
                       input logic [QW-1:0] bq, input logic ex, input logic [AW-1:0] a_s,
                       input int want_off);
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g = g + 1;
        end while (want_off >= 0 && off_m != want_off && g < 3*N);
        push(a, bq, ex, a_s);
        accept(qf, m, en, e);
        wait_done(tag, N);
    endtask

    initial begin
        int              v[N];
        logic [N*QW-1:0] qf;
        logic [N-1:0]    m;
        logic [AW-1:0]   a, a2;
        logic [QW-1:0]   bq, bq2;
        bit              seen;

        rst = 1'b1; start = 1'b0; q_flat = '0; legal_mask = '0;
        explore_en = 1'b0; eps = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy_u, 0);
        chk("rst_done", done_u, 0);
        chk("rst_action", act_u, 0);
        chk("rst_best_q", bq_u, 0);
        chk("rst_explored", expl_u, 0);
        rst = 1'b0;

        v = '{2, 3, 4, 3, 1, 6, 5, 8, 1};
        run("greedy", pack(v), 9'h1FF, 1'b0, 8'h00, 4'd8, 18'd8, 1'b0, 4'd8, -1);
        repeat (3) @(negedge clk);
        chk("hold_action", act_u, 8);
        chk("hold_best_q", bq_u, 8);

        v = '{10, 25, 23, 9, 12, 17, 55, 8, 16};
        run("masked", pack(v), 9'h1BF, 1'b0, 8'h00, 4'd2, 18'd25, 1'b0, 4'd2, -1);

        v = '{5, 5, 5, 5, 5, 5, 5, 5, 5};
        run("tie", pack(v), 9'h1FF, 1'b0, 8'h00, 4'd1, 18'd5, 1'b0, 4'd1, -1);

        v = '{'h20000, 1, 0, 0, 0, 0, 0, 0, 0};
        run("sign", pack(v), 9'h1FF, 1'b0, 8'h00, 4'd1, 18'h20000, 1'b0, 4'd2, -1);

        run("mask0", pack(v), 9'h000, 1'b0, 8'h00, 4'd0, 18'd0, 1'b0, 4'd0, -1);

        v = '{11, 22, 33, 44, 55, 66, 77, 88, 99};
        run("explore_off4", pack(v), 9'h024, 1'b1, 8'hFF, 4'd6, 18'd66, 1'b1, 4'd6, 4);
        a = ref_explore(9'h024, 7);
        run("explore_wrap", pack(v), 9'h024, 1'b1, 8'hFF, a, 18'd33, 1'b1, a, 7);
        run("eps_zero", pack(v), 9'h1FF, 1'b1, 8'h00, 4'd9, 18'd99, 1'b0, 4'd9, -1);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) v[i] = int'($urandom_range(0, (1 << QW) - 1));
            qf = pack(v);
            m  = N'($urandom_range(1, (1 << N) - 1));
            a  = ref_greedy(qf, m, 1'b0, bq);
            a2 = ref_greedy(qf, m, 1'b1, bq2);
            run("random", qf, m, 1'b0, 8'h00, a, bq, 1'b0, a2, -1);
        end

        // Start raised in the DONE cycle and held: only the IDLE edge accepts.
        v = '{7, 1, 2, 3, 4, 5, 6, 0, 9};
        qf = pack(v);
        a  = ref_greedy(qf, 9'h0FF, 1'b0, bq);
        push(a, bq, 1'b0, a);
        q_flat = qf; legal_mask = 9'h0FF; explore_en = 1'b0; eps = '0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("done_start_ignored", busy_u, 0);
        @(posedge clk);
        #1;
        start = 1'b0; q_flat = ~qf; legal_mask = '0; explore_en = 1'b1; eps = 8'hFF;
        wait_done("idle_start", N);

        // Start pulsed mid-scan with different data must not restart or re-run.
        v = '{3, 40, 2, 1, 0, 6, 5, 4, 3};
        qf = pack(v);
        @(negedge clk);
        push(4'd2, 18'd40, 1'b0, 4'd2);
        accept(qf, 9'h1FF, 1'b0, 8'h00);
        repeat (2) @(negedge clk);
        q_flat = '1; legal_mask = 9'h1FF; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("scan_start", N - 2);

        // Reset mid-scan: no done, outputs cleared.
        @(negedge clk);
        accept(qf, 9'h1FF, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (N + 4) begin
            @(negedge clk);
            if (done_u) seen = 1'b1;
        end
        chk("abort_no_done", seen, 0);
        chk("abort_action", act_u, 0);
        chk("abort_best_q", bq_u, 0);
        chk("abort_explored", expl_u, 0);
        chk("abort_busy", busy_u, 0);

        repeat (3) @(negedge clk);
        chk("done_count", done_cnt, n_dec);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
